// File: rtl/checkpoint_reg_file.sv
// Architectural register file with a circular queue of full-register snapshots
// for branch checkpointing, single-cycle rollback and combinational read ports.
module checkpoint_reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_CKPT   = 4,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*AW-1:0]         rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           ckpt_take,
    output logic [CW-1:0]                  ckpt_tag,
    output logic                           ckpt_full,
    output logic [CW:0]                    ckpt_count,
    input  logic                           ckpt_free,
    input  logic                           ckpt_restore,
    input  logic [CW-1:0]                  ckpt_restore_tag,
    output logic                           restore_done,
    output logic                           ckpt_err
);

    localparam logic [CW:0] FULL_COUNT = (CW+1)'(NUM_CKPT);

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
    logic [DATA_WIDTH-1:0] slot_r [NUM_CKPT][NUM_REGS];
    logic [CW-1:0]         head_r;
    logic [CW-1:0]         tail_r;
    logic [CW:0]           count_r;
    logic                  full_r;
    logic                  restore_done_r;
    logic                  ckpt_err_r;

    logic [CW-1:0]         dist_s;
    logic                  restore_ok_s;
    logic                  wr_ok_s;
    logic                  take_ok_s;
    logic                  free_ok_s;
    logic                  err_s;
    logic [CW:0]           count_next_s;
    logic [AW-1:0]         ra_s;

    // Request qualification and next live-slot count
    always_comb begin
        dist_s       = ckpt_restore_tag - head_r;
        restore_ok_s = ckpt_restore && ({1'b0, dist_s} < count_r);
        wr_ok_s      = wr_en && !ckpt_restore && (wr_addr != {AW{1'b0}});
        take_ok_s    = ckpt_take && !ckpt_restore && (count_r != FULL_COUNT);
        free_ok_s    = ckpt_free && !ckpt_restore && (count_r != {(CW+1){1'b0}});
        // Any rejected request, including take/free dropped by a restore
        err_s        = (ckpt_restore && !restore_ok_s)
                     || (ckpt_restore && (ckpt_take || ckpt_free))
                     || (!ckpt_restore && ckpt_take && (count_r == FULL_COUNT))
                     || (!ckpt_restore && ckpt_free && (count_r == {(CW+1){1'b0}}));
        if (restore_ok_s) begin
            count_next_s = {1'b0, dist_s};
        end else if (take_ok_s && !free_ok_s) begin
            count_next_s = count_r + (CW+1)'(1);
        end else if (free_ok_s && !take_ok_s) begin
            count_next_s = count_r - (CW+1)'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Architectural registers: rollback takes priority over the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else if (restore_ok_s) begin
            regs_r[0] <= {DATA_WIDTH{1'b0}};
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_r[k] <= slot_r[ckpt_restore_tag][k];
            end
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end else begin
            regs_r[0] <= {DATA_WIDTH{1'b0}};
        end
    end

    // Snapshot storage; the same-cycle write is merged into the copy
    always_ff @(posedge clk) begin
        if (rst_n && take_ok_s) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                slot_r[tail_r][k] <= (wr_ok_s && (wr_addr == AW'(k))) ? wr_data : regs_r[k];
            end
        end
    end

    // Queue pointers, count and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r         <= {CW{1'b0}};
            tail_r         <= {CW{1'b0}};
            count_r        <= {(CW+1){1'b0}};
            full_r         <= 1'b0;
            restore_done_r <= 1'b0;
            ckpt_err_r     <= 1'b0;
        end else begin
            if (free_ok_s) begin
                head_r <= head_r + CW'(1);
            end
            if (restore_ok_s) begin
                tail_r <= ckpt_restore_tag;
            end else if (take_ok_s) begin
                tail_r <= tail_r + CW'(1);
            end
            count_r        <= count_next_s;
            full_r         <= (count_next_s == FULL_COUNT);
            restore_done_r <= restore_ok_s;
            ckpt_err_r     <= err_s;
        end
    end

    // Combinational read ports with write bypass, suppressed during rollback
    always_comb begin
        rd_data = {(NUM_READ*DATA_WIDTH){1'b0}};
        ra_s    = {AW{1'b0}};
        for (int i = 0; i < NUM_READ; i++) begin
            ra_s = rd_addr[i*AW +: AW];
            if (!rd_en[i] || (ra_s == {AW{1'b0}})) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else if (wr_en && (wr_addr == ra_s) && !ckpt_restore) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data;
            end else begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regs_r[ra_s];
            end
        end
    end

    assign ckpt_tag     = tail_r;
    assign ckpt_count   = count_r;
    assign ckpt_full    = full_r;
    assign restore_done = restore_done_r;
    assign ckpt_err     = ckpt_err_r;

endmodule

// File: tb/tb_checkpoint_reg_file.sv
// Scenario bench for checkpoint_reg_file: expected values are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_checkpoint_reg_file;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        ckpt_take;
    logic [1:0]  ckpt_tag;
    logic        ckpt_full;
    logic [2:0]  ckpt_count;
    logic        ckpt_free;
    logic        ckpt_restore;
    logic [1:0]  ckpt_restore_tag;
    logic        restore_done;
    logic        ckpt_err;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs;
    logic [31:0] exp;

    checkpoint_reg_file dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ckpt_take(ckpt_take),
        .ckpt_tag(ckpt_tag), .ckpt_full(ckpt_full), .ckpt_count(ckpt_count),
        .ckpt_free(ckpt_free), .ckpt_restore(ckpt_restore),
        .ckpt_restore_tag(ckpt_restore_tag), .restore_done(restore_done), .ckpt_err(ckpt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        rd_en = 2'b00; rd_addr = 10'd0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        ckpt_take = 1'b0; ckpt_free = 1'b0; ckpt_restore = 1'b0; ckpt_restore_tag = 2'd0;
    endtask

    task automatic rd0(input logic [4:0] a, output logic [31:0] d);
        rd_en = 2'b01; rd_addr = {5'd0, a};
        #1;
        d = rd_data[31:0];
        rd_en = 2'b00;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rst_count: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_full); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rst_full: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_tag); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rst_tag: observed %h expected %h", obs, exp); end
        obs = {30'd0, restore_done, ckpt_err}; exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rst_pulses: observed %h expected %h", obs, exp); end
        rd0(5'd5, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL rst_r5: observed %h expected %h", obs, exp); end
        #12 rst_n = 1'b1;
        step();
    endtask

    task automatic test_bypass();
        clear_in();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        rd0(5'd5, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bypass_r5: observed %h expected %h", obs, exp); end
        step();
        wr_addr = 5'd0; wr_data = 32'h1;
        step();
        clear_in();
        exp_q.push_back(32'd0); exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
        rd0(5'd0, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL r0_zero: observed %h expected %h", obs, exp); end
        rd_en = 2'b10; rd_addr = {5'd5, 5'd0};
        #1 obs = rd_data[63:32]; exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL port1_r5: observed %h expected %h", obs, exp); end
        rd_en = 2'b01;
        #1 obs = rd_data[63:32]; exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL port1_disabled: observed %h expected %h", obs, exp); end
        clear_in();
    endtask

    task automatic test_restore_basic();
        clear_in();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        step();
        clear_in();
        exp_q.push_back(32'd0);
        obs = 32'(ckpt_tag); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL take_tag0: observed %h expected %h", obs, exp); end
        ckpt_take = 1'b1;
        exp_q.push_back(32'd1);
        step();
        clear_in();
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL take_count: observed %h expected %h", obs, exp); end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h22;
        step();
        clear_in();
        ckpt_restore = 1'b1; ckpt_restore_tag = 2'd0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'h11); exp_q.push_back(32'd0);
        step();
        clear_in();
        obs = 32'(restore_done); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restore_done_hi: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restore_count0: observed %h expected %h", obs, exp); end
        rd0(5'd3, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restore_r3: observed %h expected %h", obs, exp); end
        step();
        obs = 32'(restore_done); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL restore_done_lo: observed %h expected %h", obs, exp); end
    endtask

    task automatic test_full();
        clear_in();
        ckpt_take = 1'b1;
        exp_q.push_back(32'd1); exp_q.push_back(32'd4);
        repeat (4) step();
        obs = 32'(ckpt_full); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL full_hi: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL full_count4: observed %h expected %h", obs, exp); end
        exp_q.push_back(32'd1); exp_q.push_back(32'd4); exp_q.push_back(32'd0);
        step();
        clear_in();
        obs = 32'(ckpt_err); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL fifth_take_err: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL fifth_take_count: observed %h expected %h", obs, exp); end
        step();
        obs = 32'(ckpt_err); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL err_one_cycle: observed %h expected %h", obs, exp); end
        ckpt_take = 1'b1; ckpt_free = 1'b1;
        exp_q.push_back(32'd3); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        step();
        clear_in();
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL take_free_full_count: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_err); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL take_free_full_err: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_full); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL full_lo: observed %h expected %h", obs, exp); end
        ckpt_free = 1'b1;
        repeat (3) step();
        exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        step();
        clear_in();
        obs = 32'(ckpt_err); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL free_empty_err: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL free_empty_count: observed %h expected %h", obs, exp); end
    endtask

    task automatic test_restore_window();
        clear_in();
        for (int i = 0; i < 3; i++) begin
            ckpt_take = 1'b1; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h40 + 32'(i);
            step();
        end
        clear_in();
        ckpt_free = 1'b1;
        step();
        clear_in();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
        step();
        clear_in();
        ckpt_restore = 1'b1; ckpt_restore_tag = 2'd2;
        exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'h42);
        step();
        clear_in();
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL win_count: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_tag); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL win_tail: observed %h expected %h", obs, exp); end
        obs = 32'(restore_done); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL win_done: observed %h expected %h", obs, exp); end
        rd0(5'd4, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL win_r4_merged: observed %h expected %h", obs, exp); end
        ckpt_restore = 1'b1; ckpt_restore_tag = 2'd0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        step();
        clear_in();
        obs = 32'(ckpt_err); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bad_restore_err: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bad_restore_count: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_tag); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bad_restore_tail: observed %h expected %h", obs, exp); end
        obs = 32'(restore_done); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL bad_restore_done: observed %h expected %h", obs, exp); end
    endtask

    task automatic test_restore_write();
        clear_in();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        step();
        clear_in();
        ckpt_take = 1'b1;
        step();
        clear_in();
        ckpt_restore = 1'b1; ckpt_restore_tag = 2'd2;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        exp_q.push_back(32'h77); exp_q.push_back(32'h77); exp_q.push_back(32'd1);
        rd0(5'd7, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL no_bypass_in_restore: observed %h expected %h", obs, exp); end
        step();
        clear_in();
        rd0(5'd7, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL r7_snapshot: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL r7_count: observed %h expected %h", obs, exp); end
        ckpt_take = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        step();
        clear_in();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
        step();
        clear_in();
        ckpt_restore = 1'b1; ckpt_restore_tag = 2'd2; ckpt_free = 1'b1;
        exp_q.push_back(32'h99); exp_q.push_back(32'd3); exp_q.push_back(32'd1);
        step();
        clear_in();
        rd0(5'd9, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL r9_merged: observed %h expected %h", obs, exp); end
        obs = {30'd0, restore_done, ckpt_err}; exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL dropped_free_pulses: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL dropped_free_count: observed %h expected %h", obs, exp); end
    endtask

    task automatic test_async_reset();
        clear_in();
        ckpt_take = 1'b1;
        exp_q.push_back(32'd3);
        repeat (2) step();
        clear_in();
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL pre_reset_count: observed %h expected %h", obs, exp); end
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #2 rst_n = 1'b0;
        #1;
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL async_count: observed %h expected %h", obs, exp); end
        obs = 32'(ckpt_full); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL async_full: observed %h expected %h", obs, exp); end
        rd0(5'd9, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL async_r9: observed %h expected %h", obs, exp); end
        rd0(5'd7, obs); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL async_r7: observed %h expected %h", obs, exp); end
        @(negedge clk);
        rst_n = 1'b1;
        ckpt_take = 1'b1;
        exp_q.push_back(32'd1);
        step();
        clear_in();
        obs = 32'(ckpt_count); exp = exp_q.pop_front(); vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL post_reset_take: observed %h expected %h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_restore_basic();
        test_full();
        test_restore_window();
        test_restore_write();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/checkpoint_reg_file.md
CHECKPOINT_REG_FILE -- requirements
Module: checkpoint_reg_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, 32, register count; AW = $clog2(NUM_REGS).
REQ-003 SHALL have parameter NUM_READ, 2, number of asynchronous read ports.
REQ-004 SHALL have parameter NUM_CKPT, 4, checkpoint slots; power of 2, >=2; CW = $clog2(NUM_CKPT).
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  clock, rising edge; rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have rd_en  input  NUM_READ  per-port read enable.
REQ-007 SHALL have rd_addr  input  NUM_READ*AW  per-port read address, port i at bits [i*AW +: AW].
REQ-008 SHALL have rd_data  output  NUM_READ*DATA_WIDTH  per-port read data.
REQ-009 SHALL have wr_en, wr_addr, wr_data  input  1/AW/DATA_WIDTH  single write port.
REQ-010 SHALL have ckpt_take  input  1  request snapshot of the architectural registers.
REQ-011 SHALL have ckpt_tag  output  CW  slot that the current take will allocate.
REQ-012 SHALL have ckpt_full  output  1  all slots live.
REQ-013 SHALL have ckpt_count  output  CW+1  number of live slots.
REQ-014 SHALL have ckpt_free  input  1  release the oldest live slot (branch resolved correct).
REQ-015 SHALL have ckpt_restore, ckpt_restore_tag  input  1/CW  roll registers back to the named slot.
REQ-016 SHALL have restore_done  output  1  one-cycle pulse after an accepted restore.
REQ-017 SHALL have ckpt_err  output  1  one-cycle pulse on an illegal request.

Function
REQ-018 SHALL drive rd_data[i] combinationally: 0 if rd_en[i]=0 or rd_addr[i]=0; else wr_data if wr_en=1 and wr_addr=rd_addr[i] and no restore this cycle (bypass); else regs[rd_addr[i]].
REQ-019 SHALL write regs[wr_addr] <= wr_data at the clk edge when wr_en=1 and wr_addr!=0; register 0 always reads 0.
REQ-020 SHALL manage slots as a circular queue: head = oldest live, tail = next free, count = live slots; ckpt_tag = tail; ckpt_full = (count==NUM_CKPT).
REQ-021 SHALL accept ckpt_take when count<NUM_CKPT: slot[tail] <= regs with the same-cycle write merged, tail <= tail+1 mod NUM_CKPT, count++.
REQ-022 SHALL ignore ckpt_take when full, even if ckpt_free is high that cycle, and pulse ckpt_err.
REQ-023 SHALL on ckpt_free with count>0 set head <= head+1 mod NUM_CKPT, count--; with count=0 ignore it and pulse ckpt_err.
REQ-024 SHALL process take and free in the same cycle as: take checked against pre-cycle count; net count unchanged when both are accepted.
REQ-025 SHALL treat a restore tag as valid iff (tag-head) mod NUM_CKPT < count.
REQ-026 SHALL on a valid restore load all regs from slot[tag] in one cycle, set tail <= tag and count <= (tag-head) mod NUM_CKPT, discarding the restored slot and all younger slots.
REQ-027 SHALL in a restore cycle drop wr_en, ckpt_take and ckpt_free; a dropped take or free pulses ckpt_err.
REQ-028 SHALL ignore an invalid restore, changing no state, and pulse ckpt_err.
REQ-029 SHALL assert restore_done for exactly the cycle after an accepted restore.
REQ-030 SHALL register ckpt_err and assert it the cycle after the offending request.

Reset
REQ-031 SHALL on rst_n=0, independent of clk, clear all regs to 0, head=tail=count=0, restore_done=0, ckpt_err=0; slot contents need not be reset.
REQ-032 SHALL hold all state while rst_n=0, and any take, free or restore in progress is lost; first operation is accepted on the first clk edge after release.

Verification
REQ-033 Write r5=0xDEADBEEF, read port0 r5 same cycle -> 0xDEADBEEF via bypass; write r0=0x1 -> r0 reads 0.
REQ-034 r3=0x11; take (tag 0); r3=0x22; restore tag 0 -> r3=0x11 next cycle, restore_done pulses one cycle, count=0.
REQ-035 Four takes (NUM_CKPT=4) -> ckpt_full=1, count=4; fifth take -> ckpt_err pulse, count stays 4; take with free same cycle -> rejected, count=3.
REQ-036 Takes at tags 0,1,2; free (head=1); restore tag 2 -> count=1, tail=2; restore tag 0 -> ckpt_err, no state change.
REQ-037 Restore and wr_en r7=0x55 same cycle -> r7 equals snapshot value, not 0x55; take with r9=0x99 write same cycle, then restore -> r9=0x99.
REQ-038 rst_n low mid-sequence with count=3 -> count=0, all regs 0, ckpt_full=0 immediately without clk edge.
